// File: rtl/id_stage.sv
// id_stage: MIPS-style decode stage with register file, ID-resolved branches, hazard stall and replay.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data into register reads.
module id_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] ins_in,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_dest,
   output logic        branch_or_not,
   output logic [31:0] branch_addr,
   output logic        stall,
   output logic [31:0] idex_pc4,
   output logic [31:0] idex_rs_val,
   output logic [31:0] idex_rt_val,
   output logic [31:0] idex_imm,
   output logic [4:0]  idex_rs,
   output logic [4:0]  idex_rt,
   output logic [4:0]  idex_dest,
   output logic [3:0]  idex_alu_op,
   output logic        idex_alu_src,
   output logic        idex_reg_write,
   output logic        idex_mem_read,
   output logic        idex_mem_write
);
   typedef enum logic {NORMAL, REPLAY} state_t;
   state_t state;
   logic [31:0][31:0] rf;
   logic [31:0] hold_ins, hold_pc, ins, cur_pc, rs_val, rt_val, imm, target;
   logic [4:0] rs, rt, rd, dest;
   logic [5:0] op, fn;
   logic [3:0] alu_op;
   logic valid, alu_src, reg_write, mem_read, mem_write, use_rs, use_rt, is_br, taken;
   logic lu_haz, br_haz, wb_haz, issue;
   assign ins = (state == REPLAY) ? hold_ins : ins_in;
   assign cur_pc = (state == REPLAY) ? hold_pc : pc;
   assign op = ins[31:26];
   assign rs = ins[25:21];
   assign rt = ins[20:16];
   assign rd = ins[15:11];
   assign fn = ins[5:0];
`ifdef ID_WB_BYPASS_EN
   assign rs_val = (rs == 5'd0) ? 32'd0 : (wb_we && wb_addr == rs) ? wb_data : rf[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : (wb_we && wb_addr == rt) ? wb_data : rf[rt];
   assign wb_haz = 1'b0;
`else
   assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];
   assign wb_haz = wb_we && wb_addr != 5'd0 && ((use_rs && wb_addr == rs) || (use_rt && wb_addr == rt));
`endif
   always_comb begin
      valid = 1'b1;
      alu_op = 4'd0;
      alu_src = 1'b0;
      reg_write = 1'b1;
      mem_read = 1'b0;
      mem_write = 1'b0;
      use_rs = 1'b1;
      use_rt = 1'b0;
      dest = rt;
      imm = {{16{ins[15]}}, ins[15:0]};
      is_br = 1'b0;
      taken = 1'b0;
      target = 32'd0;
      case (op)
         6'h00: begin
            dest = rd;
            use_rt = 1'b1;
            imm = 32'd0;
            case (fn)
               6'h20, 6'h21: alu_op = 4'd0;
               6'h22, 6'h23: alu_op = 4'd1;
               6'h24: alu_op = 4'd2;
               6'h25: alu_op = 4'd3;
               6'h26: alu_op = 4'd4;
               6'h27: alu_op = 4'd5;
               6'h2a: alu_op = 4'd6;
               6'h00, 6'h02: begin
                  alu_op = fn[1] ? 4'd8 : 4'd7;
                  use_rs = 1'b0;
                  imm = {27'd0, ins[10:6]};
               end
               6'h08: begin
                  use_rt = 1'b0;
                  reg_write = 1'b0;
                  dest = 5'd0;
                  is_br = 1'b1;
                  taken = 1'b1;
                  target = rs_val;
               end
               default: valid = 1'b0;
            endcase
         end
         6'h08, 6'h09: alu_src = 1'b1;
         6'h0a: begin alu_op = 4'd6; alu_src = 1'b1; end
         6'h0c: begin alu_op = 4'd2; alu_src = 1'b1; imm = {16'd0, ins[15:0]}; end
         6'h0d: begin alu_op = 4'd3; alu_src = 1'b1; imm = {16'd0, ins[15:0]}; end
         6'h0e: begin alu_op = 4'd4; alu_src = 1'b1; imm = {16'd0, ins[15:0]}; end
         6'h0f: begin alu_op = 4'd9; alu_src = 1'b1; use_rs = 1'b0; imm = {16'd0, ins[15:0]}; end
         6'h23: begin alu_src = 1'b1; mem_read = 1'b1; end
         6'h2b: begin alu_src = 1'b1; mem_write = 1'b1; reg_write = 1'b0; use_rt = 1'b1; dest = 5'd0; end
         6'h04, 6'h05: begin
            alu_op = 4'd1;
            use_rt = 1'b1;
            reg_write = 1'b0;
            dest = 5'd0;
            is_br = 1'b1;
            taken = (rs_val == rt_val) ^ op[0];
            target = cur_pc + {imm[29:0], 2'b00};
         end
         6'h02, 6'h03: begin
            alu_op = op[0] ? 4'd10 : 4'd0;
            reg_write = op[0];
            use_rs = 1'b0;
            dest = op[0] ? 5'd31 : 5'd0;
            imm = 32'd0;
            taken = 1'b1;
            target = {cur_pc[31:28], ins[25:0], 2'b00};
         end
         default: valid = 1'b0;
      endcase
   end
   assign lu_haz = ex_mem_read && ex_dest != 5'd0 && ((use_rs && ex_dest == rs) || (use_rt && ex_dest == rt));
   assign br_haz = is_br && ex_reg_write && ex_dest != 5'd0 && ((use_rs && ex_dest == rs) || (use_rt && ex_dest == rt));
   assign stall = ~reset & valid & (lu_haz | br_haz | wb_haz);
   // A stalled branch must not redirect; the replayed copy resolves it.
   assign branch_or_not = ~reset & taken & ~stall;
   assign branch_addr = branch_or_not ? target : 32'd0;
   assign issue = valid & ~stall;
   always_ff @(posedge clk or posedge reset)
      if (reset) rf <= '0;
      else if (wb_we && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= NORMAL;
         hold_ins <= 32'd0;
         hold_pc <= 32'd0;
         idex_pc4 <= 32'd0;
         idex_rs_val <= 32'd0;
         idex_rt_val <= 32'd0;
         idex_imm <= 32'd0;
         idex_rs <= 5'd0;
         idex_rt <= 5'd0;
         idex_dest <= 5'd0;
         idex_alu_op <= 4'd0;
         idex_alu_src <= 1'b0;
         idex_reg_write <= 1'b0;
         idex_mem_read <= 1'b0;
         idex_mem_write <= 1'b0;
      end else begin
         state <= stall ? REPLAY : NORMAL;
         if (stall) begin
            hold_ins <= ins;
            hold_pc <= cur_pc;
         end
         idex_pc4 <= issue ? cur_pc + 32'd4 : 32'd0;
         idex_rs_val <= (issue && use_rs) ? rs_val : 32'd0;
         idex_rt_val <= (issue && use_rt) ? rt_val : 32'd0;
         idex_imm <= issue ? imm : 32'd0;
         idex_rs <= (issue && use_rs) ? rs : 5'd0;
         idex_rt <= (issue && use_rt) ? rt : 5'd0;
         idex_dest <= issue ? dest : 5'd0;
         idex_alu_op <= issue ? alu_op : 4'd0;
         idex_alu_src <= issue & alu_src;
         idex_reg_write <= issue & reg_write;
         idex_mem_read <= issue & mem_read;
         idex_mem_write <= issue & mem_write;
      end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: mnemonic-level reference model of id_stage with random and directed stimulus.
module tb_id_stage;
   typedef enum logic [4:0] {ADD, ADDU, SUB, SUBU, AND_, OR_, XOR_, NOR_, SLT, SLL, SRL, JR,
      ADDI, ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL, BAD} mn_t;
   typedef struct packed {
      mn_t m;
      logic [4:0] rs, rt, rd, sh;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] pc, word;
   } instr_t;
   typedef struct packed {
      logic [31:0] pc4, rsv, rtv, imm;
      logic [4:0] rs, rt, dest;
      logic [3:0] op;
      logic src, rw, mr, mw;
   } idex_t;
   logic clk = 1'b0, reset = 1'b0;
   logic [31:0] pc = 32'd0, ins_in = 32'd0, wb_data = 32'd0;
   logic wb_we = 1'b0, ex_reg_write = 1'b0, ex_mem_read = 1'b0;
   logic [4:0] wb_addr = 5'd0, ex_dest = 5'd0;
   logic branch_or_not, stall, idex_alu_src, idex_reg_write, idex_mem_read, idex_mem_write;
   logic [31:0] branch_addr, idex_pc4, idex_rs_val, idex_rt_val, idex_imm;
   logic [4:0] idex_rs, idex_rt, idex_dest;
   logic [3:0] idex_alu_op;
   int checks = 0, errors = 0;
   logic [31:0] m_rf [32];
   idex_t m_ex, nxt;
   instr_t m_hold, cur;
   logic m_held = 1'b0, stall_e = 1'b0;
   always #5 clk = ~clk;
   id_stage dut (.clk(clk), .reset(reset), .pc(pc), .ins_in(ins_in), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
      .branch_or_not(branch_or_not), .branch_addr(branch_addr), .stall(stall), .idex_pc4(idex_pc4),
      .idex_rs_val(idex_rs_val), .idex_rt_val(idex_rt_val), .idex_imm(idex_imm), .idex_rs(idex_rs),
      .idex_rt(idex_rt), .idex_dest(idex_dest), .idex_alu_op(idex_alu_op), .idex_alu_src(idex_alu_src),
      .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] encode(instr_t i);
      logic [5:0] f, o;
      f = 6'h3F;
      o = 6'h3F;
      case (i.m)
         ADD: f = 6'h20; ADDU: f = 6'h21; SUB: f = 6'h22; SUBU: f = 6'h23;
         AND_: f = 6'h24; OR_: f = 6'h25; XOR_: f = 6'h26; NOR_: f = 6'h27;
         SLT: f = 6'h2a; SLL: f = 6'h00; SRL: f = 6'h02; JR: f = 6'h08;
         ADDI: o = 6'h08; ADDIU: o = 6'h09; SLTI: o = 6'h0a; ANDI: o = 6'h0c;
         ORI: o = 6'h0d; XORI: o = 6'h0e; LUI: o = 6'h0f; LW: o = 6'h23;
         SW: o = 6'h2b; BEQ: o = 6'h04; BNE: o = 6'h05; J: o = 6'h02; JAL: o = 6'h03;
         default: ;
      endcase
      if (i.m == BAD) begin
         case (i.sh[2:0])
            3'd0: o = 6'h3F; 3'd1: o = 6'h01; 3'd2: o = 6'h06; 3'd3: o = 6'h07;
            3'd4: o = 6'h10; 3'd5: o = 6'h20; default: o = 6'h28;
         endcase
         return i.sh[3] ? {6'h00, i.idx[25:6], 6'h01} : {o, i.idx};
      end
      if (f != 6'h3F) return {6'd0, i.rs, i.rt, i.rd, i.sh, f};
      if (i.m inside {J, JAL}) return {o, i.idx};
      return {o, i.rs, i.rt, i.imm};
   endfunction
   function automatic instr_t mk(mn_t m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                 logic [15:0] imm, logic [25:0] idx, logic [31:0] p);
      instr_t i;
      i.m = m; i.rs = rs; i.rt = rt; i.rd = rd; i.sh = 5'd0;
      i.imm = imm; i.idx = idx; i.pc = p;
      i.word = encode(i);
      return i;
   endfunction
   function automatic instr_t rnd_instr();
      instr_t i;
      i.m = mn_t'($urandom_range(0, 25));
      i.rs = 5'($urandom_range(0, 7));
      i.rt = 5'($urandom_range(0, 7));
      i.rd = 5'($urandom_range(0, 7));
      i.sh = 5'($urandom);
      i.imm = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 8));
      i.idx = 26'($urandom);
      i.pc = $urandom & 32'hFFFF_FFFC;
      i.word = encode(i);
      return i;
   endfunction
   function automatic logic uses_rs(mn_t m);
      return m inside {ADD, ADDU, SUB, SUBU, AND_, OR_, XOR_, NOR_, SLT, JR,
                       ADDI, ADDIU, SLTI, ANDI, ORI, XORI, LW, SW, BEQ, BNE};
   endfunction
   function automatic logic uses_rt(mn_t m);
      return m inside {ADD, ADDU, SUB, SUBU, AND_, OR_, XOR_, NOR_, SLT, SLL, SRL, SW, BEQ, BNE};
   endfunction
   function automatic logic [3:0] alu_of(mn_t m);
      case (m)
         SUB, SUBU, BEQ, BNE: return 4'd1;
         AND_, ANDI: return 4'd2;
         OR_, ORI: return 4'd3;
         XOR_, XORI: return 4'd4;
         NOR_: return 4'd5;
         SLT, SLTI: return 4'd6;
         SLL: return 4'd7;
         SRL: return 4'd8;
         LUI: return 4'd9;
         JAL: return 4'd10;
         default: return 4'd0;
      endcase
   endfunction
   function automatic logic [31:0] m_read(logic [4:0] r);
      if (r == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
      if (wb_we && wb_addr == r) return wb_data;
`endif
      return m_rf[r];
   endfunction
   function automatic logic hit(instr_t i, logic [4:0] r);
      return (uses_rs(i.m) && i.rs == r) || (uses_rt(i.m) && i.rt == r);
   endfunction
   function automatic idex_t expect_ex(instr_t i, logic [31:0] rsv, logic [31:0] rtv);
      idex_t e;
      logic [31:0] sx;
      e = '0;
      sx = {{16{i.imm[15]}}, i.imm};
      if (i.m == BAD) return e;
      e.pc4 = i.pc + 32'd4;
      e.rs = uses_rs(i.m) ? i.rs : 5'd0;
      e.rt = uses_rt(i.m) ? i.rt : 5'd0;
      e.rsv = rsv;
      e.rtv = rtv;
      e.op = alu_of(i.m);
      e.src = i.m inside {ADDI, ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW, SW};
      e.mr = (i.m == LW);
      e.mw = (i.m == SW);
      e.rw = i.m inside {ADD, ADDU, SUB, SUBU, AND_, OR_, XOR_, NOR_, SLT, SLL, SRL,
                         ADDI, ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW, JAL};
      e.dest = (i.m == JAL) ? 5'd31 :
               (i.m inside {ADD, ADDU, SUB, SUBU, AND_, OR_, XOR_, NOR_, SLT, SLL, SRL}) ? i.rd :
               (i.m inside {ADDI, ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW}) ? i.rt : 5'd0;
      e.imm = (i.m inside {ADDI, ADDIU, SLTI, LW, SW, BEQ, BNE}) ? sx :
              (i.m inside {ANDI, ORI, XORI, LUI}) ? {16'd0, i.imm} :
              (i.m inside {SLL, SRL}) ? {27'd0, i.sh} : 32'd0;
      return e;
   endfunction
   // Present one fetched instruction, then compare every output with the model at the falling edge.
   task automatic apply(input instr_t f);
      logic [31:0] rsv, rtv, tgt, sx;
      logic tk, br_e;
      pc = f.pc;
      ins_in = f.word;
      @(negedge clk);
      cur = m_held ? m_hold : f;
      rsv = uses_rs(cur.m) ? m_read(cur.rs) : 32'd0;
      rtv = uses_rt(cur.m) ? m_read(cur.rt) : 32'd0;
      sx = {{16{cur.imm[15]}}, cur.imm};
      stall_e = (ex_mem_read && ex_dest != 5'd0 && hit(cur, ex_dest)) ||
                (cur.m inside {BEQ, BNE, JR} && ex_reg_write && ex_dest != 5'd0 && hit(cur, ex_dest));
`ifndef ID_WB_BYPASS_EN
      stall_e = stall_e || (wb_we && wb_addr != 5'd0 && hit(cur, wb_addr));
`endif
      tk = (cur.m == BEQ) ? (rsv == rtv) : (cur.m == BNE) ? (rsv != rtv) : (cur.m inside {JR, J, JAL});
      tgt = (cur.m inside {BEQ, BNE}) ? cur.pc + (sx << 2) :
            (cur.m == JR) ? rsv : {cur.pc[31:28], cur.idx, 2'b00};
      br_e = tk && !stall_e;
      chk("stall", 32'(stall), 32'(stall_e));
      chk("branch_or_not", 32'(branch_or_not), 32'(br_e));
      chk("branch_addr", branch_addr, br_e ? tgt : 32'd0);
      chk("idex_pc4", idex_pc4, m_ex.pc4);
      chk("idex_rs_val", idex_rs_val, m_ex.rsv);
      chk("idex_rt_val", idex_rt_val, m_ex.rtv);
      chk("idex_imm", idex_imm, m_ex.imm);
      chk("idex_rs", 32'(idex_rs), 32'(m_ex.rs));
      chk("idex_rt", 32'(idex_rt), 32'(m_ex.rt));
      chk("idex_dest", 32'(idex_dest), 32'(m_ex.dest));
      chk("idex_alu_op", 32'(idex_alu_op), 32'(m_ex.op));
      chk("idex_ctl", {28'd0, idex_alu_src, idex_reg_write, idex_mem_read, idex_mem_write},
          {28'd0, m_ex.src, m_ex.rw, m_ex.mr, m_ex.mw});
      nxt = stall_e ? '0 : expect_ex(cur, rsv, rtv);
   endtask
   task automatic advance();
      @(posedge clk);
      if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
      m_ex = nxt;
      m_held = stall_e;
      m_hold = cur;
      #1;
   endtask
   task automatic mid_reset();
      reset = 1'b1;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_branch", 32'(branch_or_not), 32'd0);
      chk("rst_pc4_imm", idex_pc4 | idex_imm, 32'd0);
      chk("rst_vals", idex_rs_val | idex_rt_val, 32'd0);
      chk("rst_idx", {17'd0, idex_rs, idex_rt, idex_dest}, 32'd0);
      chk("rst_ctl", {24'd0, idex_alu_op, idex_alu_src, idex_reg_write, idex_mem_read, idex_mem_write}, 32'd0);
      for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
      m_ex = '0;
      m_held = 1'b0;
      stall_e = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask
   task automatic quiet();
      wb_we = 1'b0;
      ex_mem_read = 1'b0;
      ex_reg_write = 1'b0;
      ex_dest = 5'd0;
   endtask
   initial begin
      instr_t fill;
      fill = mk(LUI, 5'd0, 5'd1, 5'd0, 16'h0001, 26'd0, 32'h0000_0100);
      #2 mid_reset();
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
      apply(mk(ADD, 5'd0, 5'd0, 5'd2, 16'd0, 26'd0, 32'h0000_0010));
      chk("r0_write_no_stall", 32'(stall), 32'd0);
      advance();
      quiet();
      apply(mk(OR_, 5'd0, 5'd0, 5'd3, 16'd0, 26'd0, 32'h0000_0014));
      advance();
      apply(fill);
      chk("r0_reads_zero", idex_rs_val, 32'd0);
      chk("r0_or_dest", 32'(idex_dest), 32'd3);
      advance();
      apply(mk(BAD, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000_123, 32'h0000_0020));
      chk("bad_branch", 32'(branch_or_not), 32'd0);
      advance();
      apply(fill);
      chk("bad_bubble", {24'd0, idex_alu_op, idex_alu_src, idex_reg_write, idex_mem_read, idex_mem_write}, 32'd0);
      chk("bad_pc4", idex_pc4, 32'd0);
      advance();
      wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'd5;
      apply(fill);
      advance();
      wb_addr = 5'd9;
      apply(fill);
      advance();
      quiet();
      apply(mk(BEQ, 5'd8, 5'd9, 5'd0, 16'd3, 26'd0, 32'h0000_0044));
      chk("beq_taken", 32'(branch_or_not), 32'd1);
      chk("beq_target", branch_addr, 32'h0000_0050);
      advance();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd8;
      apply(mk(ADD, 5'd8, 5'd9, 5'd10, 16'd0, 26'd0, 32'h0000_004C));
      chk("loaduse_stall", 32'(stall), 32'd1);
      advance();
      quiet();
      apply(mk(XORI, 5'd1, 5'd2, 5'd0, 16'h7777, 26'd0, 32'h0000_0050));
      chk("replay_no_stall", 32'(stall), 32'd0);
      chk("loaduse_bubble", {27'd0, idex_dest} | 32'(idex_reg_write), 32'd0);
      advance();
      apply(fill);
      chk("replay_rs", 32'(idex_rs), 32'd8);
      chk("replay_dest", 32'(idex_dest), 32'd10);
      advance();
      apply(mk(JAL, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100, 32'h0004_000C));
      chk("jal_taken", 32'(branch_or_not), 32'd1);
      chk("jal_target", branch_addr, 32'h0000_0400);
      advance();
      apply(fill);
      chk("jal_dest", 32'(idex_dest), 32'd31);
      chk("jal_pc4", idex_pc4, 32'h0004_0010);
      advance();
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_00AA;
      apply(mk(ADD, 5'd3, 5'd0, 5'd4, 16'd0, 26'd0, 32'h0000_0060));
`ifdef ID_WB_BYPASS_EN
      chk("bypass_no_stall", 32'(stall), 32'd0);
      advance();
      quiet();
`else
      chk("wb_stall", 32'(stall), 32'd1);
      advance();
      quiet();
      apply(fill);
      chk("wb_replay_go", 32'(stall), 32'd0);
      advance();
`endif
      apply(fill);
      chk("wb_value", idex_rs_val, 32'h0000_00AA);
      advance();
      for (int n = 0; n < 3000; n++) begin
         wb_we = 1'($urandom_range(0, 1));
         wb_addr = 5'($urandom_range(0, 7));
         wb_data = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
         ex_mem_read = ($urandom_range(0, 3) == 0);
         ex_reg_write = 1'($urandom_range(0, 1));
         ex_dest = 5'($urandom_range(0, 7));
         apply(rnd_instr());
         advance();
      end
      quiet();
      apply(mk(ORI, 5'd0, 5'd6, 5'd0, 16'h0042, 26'd0, 32'h0000_0200));
      advance();
      ex_mem_read = 1'b1; ex_dest = 5'd7;
      apply(mk(SUB, 5'd7, 5'd7, 5'd1, 16'd0, 26'd0, 32'h0000_0204));
      chk("pre_reset_stall", 32'(stall), 32'd1);
      advance();
      apply(fill);
      chk("still_stalled", 32'(stall), 32'd1);
      mid_reset();
      quiet();
      apply(mk(ORI, 5'd0, 5'd5, 5'd0, 16'h1234, 26'd0, 32'h0000_0300));
      advance();
      apply(fill);
      chk("post_reset_dest", 32'(idex_dest), 32'd5);
      chk("post_reset_imm", idex_imm, 32'h0000_1234);
      advance();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
